// File: rtl/down_sample_multi_if.sv
// Bus bundle for down_sample_multi: rate/mode control, packed input samples
// with their qualifier, and the decimated outputs with strobe and count.
interface down_sample_multi_if #(
  parameter int DATA_W = 12,
  parameter int CH_NUM = 2,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
);
  logic [ACC_W-1:0]         sample_fre;
  logic [1:0]               mode;
  logic [4:0]               avg_shift;
  logic [CH_NUM*DATA_W-1:0] data_in;
  logic                     data_in_valid;
  logic                     clk_sample;
  logic [CH_NUM*DATA_W-1:0] data_out;
  logic                     data_valid;
  logic [CNT_W-1:0]         cnt_out;

  // Source side: drives rate, mode and samples; observes the decimated stream.
  modport master (
    output sample_fre, mode, avg_shift, data_in, data_in_valid,
    input  clk_sample, data_out, data_valid, cnt_out
  );

  // Decimator side.
  modport slave (
    input  sample_fre, mode, avg_shift, data_in, data_in_valid,
    output clk_sample, data_out, data_valid, cnt_out
  );
endinterface

// File: rtl/down_sample_multi.sv
// Multi-channel decimator. A phase accumulator produces the sample strobe on
// the rising edge of its MSB; at each strobe one word per channel is emitted
// (pick / average / peak of the interval that ends on the strobe cycle).
module down_sample_multi #(
  parameter int DATA_W = 12,
  parameter int CH_NUM = 2,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                i_clk_AD,
  input  logic                i_rst,
  down_sample_multi_if.slave  bus
);

  localparam int SUM_W = DATA_W + CNT_W;
  // One extra bit so the strobe-cycle total (sum + last sample) never wraps.
  localparam int TOT_W = SUM_W + 1;
  localparam logic [DATA_W-1:0] DATA_MAX = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  // Saturating increment of the shared interval count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  // Unsigned maximum of two samples.
  function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Truncating right shift of the interval total, clipped to full scale.
  function automatic logic [DATA_W-1:0] avg_sat(input logic [TOT_W-1:0] tot,
                                                input logic [4:0] sh);
    logic [TOT_W-1:0] q;
    q = tot >> sh;
    if (q > TOT_W'(DATA_MAX)) begin
      return DATA_MAX;
    end else begin
      return q[DATA_W-1:0];
    end
  endfunction

  logic [ACC_W-1:0]         r_addr;
  logic                     r_clk_sample_buf;
  logic [1:0]               r_mode;
  logic [CNT_W-1:0]         r_count;
  logic [SUM_W-1:0]         r_sum  [CH_NUM];
  logic [DATA_W-1:0]        r_peak [CH_NUM];
  logic [DATA_W-1:0]        r_hold [CH_NUM];
  logic [CH_NUM*DATA_W-1:0] r_data_out;
  logic                     r_data_valid;
  logic [CNT_W-1:0]         r_cnt_out;

  logic                     w_clk_sample;
  logic                     w_pose;
  logic                     w_valid;
  logic [CNT_W-1:0]         w_count_nxt;
  logic [DATA_W-1:0]        w_x    [CH_NUM];
  logic [DATA_W-1:0]        w_xv   [CH_NUM];
  logic [TOT_W-1:0]         w_tot  [CH_NUM];
  logic [CH_NUM*DATA_W-1:0] w_data_out;

  assign w_valid      = bus.data_in_valid;
  assign w_clk_sample = r_addr[ACC_W-1];
  assign w_pose       = w_clk_sample & ~r_clk_sample_buf;
  // Count including the current cycle; also the value reported at a strobe.
  assign w_count_nxt  = sat_inc(r_count, w_valid);

  assign bus.clk_sample = w_clk_sample;
  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.cnt_out    = r_cnt_out;

  // Phase accumulator, strobe edge buffer and the mode latched per interval.
  always_ff @(posedge i_clk_AD) begin
    if (i_rst) begin
      r_addr           <= {ACC_W{1'b0}};
      r_clk_sample_buf <= 1'b0;
      r_mode           <= 2'd0;
    end else begin
      r_addr           <= r_addr + bus.sample_fre;
      r_clk_sample_buf <= w_clk_sample;
      if (w_pose) begin
        r_mode <= bus.mode;
      end else begin
        r_mode <= r_mode;
      end
    end
  end

  // Shared count of valid inputs in the running interval.
  always_ff @(posedge i_clk_AD) begin
    if (i_rst || w_pose) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Per-channel sum/peak/hold; the strobe cycle closes the interval.
  always_ff @(posedge i_clk_AD) begin
    for (int c = 0; c < CH_NUM; c++) begin
      if (i_rst) begin
        r_sum[c]  <= {SUM_W{1'b0}};
        r_peak[c] <= {DATA_W{1'b0}};
        r_hold[c] <= {DATA_W{1'b0}};
      end else if (w_pose) begin
        r_sum[c]  <= {SUM_W{1'b0}};
        r_peak[c] <= {DATA_W{1'b0}};
        if (w_valid) begin
          r_hold[c] <= w_x[c];
        end else begin
          r_hold[c] <= r_hold[c];
        end
      end else if (w_valid) begin
        r_sum[c]  <= r_sum[c] + SUM_W'(w_x[c]);
        r_peak[c] <= max_u(r_peak[c], w_x[c]);
        r_hold[c] <= w_x[c];
      end else begin
        r_sum[c]  <= r_sum[c];
        r_peak[c] <= r_peak[c];
        r_hold[c] <= r_hold[c];
      end
    end
  end

  // Result of the interval ending this cycle, selected by the latched mode.
  always_comb begin
    w_data_out = {(CH_NUM*DATA_W){1'b0}};
    for (int c = 0; c < CH_NUM; c++) begin
      w_x[c]   = bus.data_in[c*DATA_W +: DATA_W];
      w_xv[c]  = w_valid ? w_x[c] : {DATA_W{1'b0}};
      w_tot[c] = {1'b0, r_sum[c]} + TOT_W'(w_xv[c]);
      case (r_mode)
        2'd1:    w_data_out[c*DATA_W +: DATA_W] = avg_sat(w_tot[c], bus.avg_shift);
        2'd2:    w_data_out[c*DATA_W +: DATA_W] = max_u(r_peak[c], w_xv[c]);
        default: w_data_out[c*DATA_W +: DATA_W] = w_valid ? w_x[c] : r_hold[c];
      endcase
    end
  end

  // Registered outputs: words and count update with a one-cycle valid pulse.
  always_ff @(posedge i_clk_AD) begin
    if (i_rst) begin
      r_data_out   <= {(CH_NUM*DATA_W){1'b0}};
      r_data_valid <= 1'b0;
      r_cnt_out    <= {CNT_W{1'b0}};
    end else begin
      r_data_valid <= w_pose;
      if (w_pose) begin
        r_data_out <= w_data_out;
        r_cnt_out  <= w_count_nxt;
      end else begin
        r_data_out <= r_data_out;
        r_cnt_out  <= r_cnt_out;
      end
    end
  end

endmodule

// File: doc/down_sample_multi.md
Name: down_sample_multi

Overview:
Parametrised multi-channel decimator for the AD front end, ahead of the FFT capture path. A phase accumulator clocked by the AD clock generates the sampling strobe (sample_fre = Fs*2^ACC_W/Fc). Each strobe emits one decimated word per channel, in one of three run-time modes:
- pick: latest sample.
- average: shifted sum over the interval.
- peak: per-interval maximum.

Parameters:
DATA_W, 12, bits per channel sample (unsigned offset binary).
CH_NUM, 2, number of parallel channels.
ACC_W, 32, phase accumulator width.
CNT_W, 16, interval sample counter width.

Ports:
clk_AD  in  1  AD clock; all logic on rising edge.
rst  in  1  synchronous reset, active-high.
sample_fre  in  ACC_W  phase increment per clk_AD cycle.
mode  in  2  0=pick, 1=average, 2=peak, 3=reserved (treated as pick).
avg_shift  in  5  right shift applied to the interval sum in average mode.
data_in  in  CH_NUM*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
data_in_valid  in  1  qualifies data_in in the current cycle.
clk_sample  out  1  decimated sample clock, equal to addr MSB.
data_out  out  CH_NUM*DATA_W  decimated words, same packing as data_in.
data_valid  out  1  one-cycle pulse; data_out updated this cycle.
cnt_out  out  CNT_W  valid inputs accumulated into the last emitted interval.

Behaviour:
- Reset state: addr=0, clk_sample=0, edge buffer=0, data_out=0, data_valid=0, cnt_out=0, mode_r=0, all per-channel sum/peak/hold registers=0, interval count=0.
- Reset mid-interval discards the partial interval. No data_valid is emitted while rst is high or in the cycle rst deasserts.
- Phase accumulator:
  - addr <= addr + sample_fre each cycle, modulo 2^ACC_W.
  - clk_sample = addr[ACC_W-1], combinational from the register.
- Strobe:
  - clk_sample_buf <= clk_sample each cycle.
  - pose = clk_sample & ~clk_sample_buf.
  - sample_fre=0 gives no pose; clk_sample stays at its current MSB.
  - sample_fre >= 2^(ACC_W-1) aliases. This is legal, with no special handling; the minimum pose spacing is 2 cycles.
- Interval definition: the interval ending at a pose cycle contains every cycle after the previous pose, up to and including the pose cycle. Only cycles with data_in_valid=1 contribute.
- Per-channel state:
  - sum, width DATA_W+CNT_W.
  - peak, width DATA_W.
  - hold, width DATA_W, holding the last valid sample (never cleared except by reset).
- Shared state: count, width CNT_W, saturating at all-ones.
- Non-pose cycle with data_in_valid=1:
  - sum += x; peak = max(peak, x); hold = x; count += 1 (saturating).
- Pose cycle (registered, so visible the next cycle together with data_valid=1), with x' = data_in if valid else none:
  - pick: data_out_c = x' if valid, else hold_c.
  - average: s = (sum_c + x') >> avg_shift; data_out_c = s saturated to 2^DATA_W-1.
  - peak: data_out_c = max(peak_c, x'). An interval with no valid input outputs 0.
  - cnt_out = count + valid, saturating.
  - Then sum=0, peak=0, count=0; hold = x' if valid.
- Latency: data_out and data_valid assert exactly 1 cycle after the pose cycle. clk_sample is unregistered relative to addr.
- Mode latching:
  - mode is sampled into mode_r at each pose and governs the next interval.
  - The first interval after reset uses pick.
  - avg_shift is sampled live in the pose cycle.
- Averaging arithmetic: unsigned, truncating shift with no rounding. A zero-count interval in average mode outputs 0.
- Channels are independent; a single valid qualifies all channels.

Test Plan:
1. Pick: sample_fre=32'h4000_0000, data_in_valid=1, ch0 ramp 0,1,2,… from reset release (cycle k carries value k). Required: clk_sample is 0 for 2 cycles then 1 for 2 cycles; pose first at addr=32'h8000_0000 (cycle 2); data_valid every 4 cycles; data_out ch0 = 2, 6, 10, …; cnt_out=3 first, then 4.
2. Average:
   - Setup: same clock ramp, mode=1 applied before the first pose, avg_shift=2.
   - From the second interval on, ch0 samples n..n+3 give data_out = (4n+6)>>2 = n+1. Sequence: 4, 8, …
   - ch1 held at 12'h800 outputs 12'h800.
3. Peak with saturation:
   - Stimulus: mode=2, ch0 samples {5, 12'hFFE, 3, 7} per interval. Required: data_out=12'hFFE.
   - Stimulus: mode=1, avg_shift=0, ch0=12'hFFF for 4 samples. Required: data_out=12'hFFF (saturated), cnt_out=4.
4. Valid gaps: data_in_valid low for the last 3 cycles of an interval, including the pose cycle. Required:
   - pick returns the last valid sample.
   - cnt_out counts valid cycles only.
   - A fully invalid interval gives pick=hold, average=0, peak=0, cnt_out=0.
5. Reset/boundaries:
   - rst pulsed mid-interval: outputs return to 0 and no data_valid appears from that interval.
   - sample_fre=0: no data_valid over 1000 cycles.
   - sample_fre=32'h8000_0000: data_valid every 2 cycles.
   - addr wraps 32'hFFFF_FFFF→0 without a spurious pose.
